fp8_stream_pack: RTL and testbench
==================================

Name: fp8_stream_pack

Overview:
Streaming, pipelined FP32→FP8 converter that feeds the systolic array's FP8 operand buffers. Each beat carries LANES FP32 values. All lanes convert in parallel to OCP FP8, with the format (E4M3 or E5M2) selected per beat. Valid/ready handshakes are on both sides, with per-beat saturation flags and a sticky, clearable saturation counter.

Parameters:
LANES, 4, number of FP32 values per beat (1..16)
CNT_W, 16, width of the saturation event counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block accepts beat when in_valid&&in_ready
in_data  in  32*LANES  lane i at bits [32i+31:32i]
in_fmt  in  1  0=E4M3 (bias 7), 1=E5M2 (bias 15); sampled with the beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts when out_valid&&out_ready
out_data  out  8*LANES  lane i at bits [8i+7:8i]
out_sat  out  LANES  per-lane saturation flag for the output beat
out_fmt  out  1  format of the output beat
sat_count  out  CNT_W  total saturated lanes since reset/clear
clr_cnt  in  1  synchronous clear of sat_count

Behaviour:
- One clock; reset is synchronous, active-low (rst_n sampled on rising clk).
- Reset: out_valid=0, out_data=0, out_sat=0, out_fmt=0, sat_count=0, internal stage valids=0. in_ready=1 in the cycle after reset.
- Pipeline has 2 stages:
  - S1 registers unpacked sign/exponent/mantissa plus class (zero, NaN, inf, normal).
  - S2 registers rounded and packed FP8 plus flags.
- Latency: an accepted beat appears on out_valid 2 cycles later if not stalled.
- Advance rules:
  - s2_load = !s2_valid || out_ready
  - s1_load = !s1_valid || s2_load
  - in_ready = s1_load (combinational from out_ready)
- Full throughput is 1 beat/clk when out_ready=1. Bubbles collapse.
- Stall: out_data, out_sat and out_fmt hold stable while out_valid&&!out_ready. No beat is dropped or duplicated.
- Data changes only on acceptance. in_data and in_fmt are ignored when in_valid=0.
- Conversion, per lane, for the beat's format:
  - Rounding is round-to-nearest-even on the discarded mantissa bits (guard/round/sticky).
  - A mantissa carry increments the exponent.
  - FP32 zero or FP32 subnormal → signed zero (0x00/0x80), sat=0.
  - NaN → canonical NaN with the input sign: E4M3 s.1111.111, E5M2 s.11111.10. sat=0.
  - ±Inf or finite magnitude above max after rounding → signed max finite, sat=1.
    - E4M3 max 448 (0x7E).
    - E5M2 max 57344 (0x7B).
  - Results below the min normal → FP8 subnormal with RNE. Underflow to zero gives signed zero, sat=0.
- Counter:
  - Each cycle where out_valid&&out_ready, sat_count += popcount(out_sat).
  - The counter saturates at 2^CNT_W-1 and does not wrap.
  - clr_cnt=1 sets sat_count to 0 that cycle and wins over a simultaneous increment. That beat's events are discarded.
- Reset mid-stream: all in-flight beats are discarded and no partial beat is emitted. sat_count=0.

Test Plan:
- Single lane 0, E4M3: 0x3F800000 (1.0)→0x38; 0xC0000000 (-2.0)→0xC0; 0x3F000000 (0.5)→0x30. E5M2: 1.0→0x3C. out_valid exactly 2 clk after acceptance, out_sat=0.
- RNE ties in E4M3: 0x3F880000 (1.0625)→0x38; 0x3F980000 (1.1875)→0x3A. Subnormal: 0x3B000000 (2^-9)→0x01. FP32 subnormal 0x00000001→0x00.
- Saturation/special in E4M3: 0x43E00000 (448)→0x7E, sat=0; 0x447A0000 (1000)→0x7E, sat=1; 0xFF800000 (-Inf)→0xFE, sat=1. NaN 0x7FC00000→0x7F (E4M3), 0x7E (E5M2). After acceptance, sat_count=2.
- Backpressure: 8 back-to-back beats with alternating in_fmt, out_ready toggled randomly. Output order, formats and data match a reference model. Outputs are stable during stalls. in_ready=0 only while both stages are full and out_ready=0.
- Counter: 4 lanes all saturating over 3 beats gives sat_count=12. Asserting clr_cnt together with a saturating beat gives 0 next cycle. With CNT_W=4 forced near max, the count holds at 15.
- Reset: assert rst_n=0 with 2 beats in flight. Next cycle out_valid=0, sat_count=0 and in_ready=1, and no stale beat appears afterwards.

Source files
------------

// File: rtl/fp8_stream_pack.sv
// Two-stage FP32 -> OCP FP8 (E4M3 / E5M2) lane-parallel converter with valid/ready
// handshakes on both sides, per-lane saturation flags and a saturating event counter.
module fp8_stream_pack #(
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [32*LANES-1:0] in_data,
  input  logic                in_fmt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*LANES-1:0]  out_data,
  output logic [LANES-1:0]    out_sat,
  output logic                out_fmt,
  output logic [CNT_W-1:0]    sat_count,
  input  logic                clr_cnt
);

  localparam logic [1:0] ClsZero = 2'd0;
  localparam logic [1:0] ClsNorm = 2'd1;
  localparam logic [1:0] ClsInf  = 2'd2;
  localparam logic [1:0] ClsNan  = 2'd3;
  localparam int unsigned PopW = $clog2(LANES + 1);

  logic                   s1_valid, s1_fmt, s1_load, s2_load;
  logic [LANES-1:0]       s1_sign;
  logic [LANES-1:0][7:0]  s1_exp;
  logic [LANES-1:0][22:0] s1_man;
  logic [LANES-1:0][1:0]  s1_cls;
  logic [LANES-1:0][1:0]  in_cls;
  logic [8*LANES-1:0]     conv_data;
  logic [LANES-1:0]       conv_sat;
  logic [PopW-1:0]        pop;
  logic [CNT_W:0]         cnt_sum;

  function automatic logic [8:0] fp8_conv(input logic sgn, input logic [7:0] ex,
                                          input logic [22:0] man, input logic [1:0] cls,
                                          input logic fmt);
    int          mbits, bias, max_mag, e, sh, tef, mag;
    logic [31:0] sig, kept, rem, half;
    logic        rnd;
    logic [6:0]  max7;
    mbits   = fmt ? 2 : 3;
    bias    = fmt ? 15 : 7;
    max7    = fmt ? 7'h7b : 7'h7e;
    max_mag = int'(max7);
    e       = int'(ex) - 127;
    // Below the min normal the quantum stops shrinking, so the shift grows instead.
    sh      = 23 - mbits + ((1 - bias - e > 0) ? (1 - bias - e) : 0);
    if (sh > 31) sh = 31;
    sig  = {8'd0, 1'b1, man};
    kept = sig >> sh;
    rem  = sig & ((32'd1 << sh) - 32'd1);
    half = 32'd1 << (sh - 1);
    rnd  = (rem > half) || ((rem == half) && kept[0]);
    tef  = (e + bias < 1) ? 1 : e + bias;
    // A rounding carry out of the mantissa ripples into the exponent field here.
    mag  = ((tef - 1) << mbits) + int'(kept) + int'(rnd);
    case (cls)
      ClsZero: fp8_conv = {1'b0, sgn, 7'h00};
      ClsNan:  fp8_conv = {1'b0, sgn, fmt ? 7'h7e : 7'h7f};
      ClsInf:  fp8_conv = {1'b1, sgn, max7};
      default: fp8_conv = (mag > max_mag) ? {1'b1, sgn, max7} : {1'b0, sgn, mag[6:0]};
    endcase
  endfunction

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  always_comb begin
    in_cls = '0;
    for (int i = 0; i < LANES; i++) begin
      if (in_data[32*i+23 +: 8] == 8'h00)      in_cls[i] = ClsZero;
      else if (in_data[32*i+23 +: 8] != 8'hff) in_cls[i] = ClsNorm;
      else if (in_data[32*i +: 23] == '0)      in_cls[i] = ClsInf;
      else                                     in_cls[i] = ClsNan;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_fmt   <= 1'b0;
      s1_sign  <= '0;
      s1_exp   <= '0;
      s1_man   <= '0;
      s1_cls   <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_fmt <= in_fmt;
        s1_cls <= in_cls;
        for (int i = 0; i < LANES; i++) begin
          s1_sign[i] <= in_data[32*i+31];
          s1_exp[i]  <= in_data[32*i+23 +: 8];
          s1_man[i]  <= in_data[32*i +: 23];
        end
      end
    end
  end

  always_comb begin
    conv_data = '0;
    conv_sat  = '0;
    for (int i = 0; i < LANES; i++) begin
      {conv_sat[i], conv_data[8*i +: 8]} =
          fp8_conv(s1_sign[i], s1_exp[i], s1_man[i], s1_cls[i], s1_fmt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
      out_fmt   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= conv_data;
        out_sat  <= conv_sat;
        out_fmt  <= s1_fmt;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + PopW'(out_sat[i]);
    end
    cnt_sum = {1'b0, sat_count} + (CNT_W + 1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      sat_count <= '0;
    end else if (out_valid && out_ready) begin
      sat_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_fp8_stream_pack.sv
// Bench for fp8_stream_pack: constant vector table, scoreboard against a value-search
// FP8 reference, backpressure, counter saturation/clear and mid-stream reset.
module tb_fp8_stream_pack;
  localparam int LANES = 4;

  typedef struct packed {
    logic               fmt;
    logic [LANES-1:0]   sat;
    logic [8*LANES-1:0] data;
  } beat_t;

  typedef struct {
    logic [31:0] x;
    logic        fmt;
    logic [7:0]  d;
    logic        sat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_fmt, out_ready, clr_cnt;
  logic [32*LANES-1:0] in_data;
  logic in_ready, out_valid, out_fmt;
  logic [8*LANES-1:0] out_data;
  logic [LANES-1:0] out_sat;
  logic [15:0] sat_count;
  logic in_ready2, out_valid2, out_fmt2;
  logic [8*LANES-1:0] out_data2;
  logic [LANES-1:0] out_sat2;
  logic [3:0] sat_count2;

  beat_t sb[$];
  beat_t tab_exp, prev_out;
  logic use_table = 1'b1;
  logic prev_stall = 1'b0;
  int errors = 0;
  int checks = 0;
  vec_t vt[13];

  fp8_stream_pack #(.LANES(LANES), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_fmt(in_fmt), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .out_fmt(out_fmt), .sat_count(sat_count), .clr_cnt(clr_cnt)
  );

  // Narrow-counter copy sharing the same stimulus, used for the hold-at-max check.
  fp8_stream_pack #(.LANES(LANES), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_fmt(in_fmt), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_sat(out_sat2), .out_fmt(out_fmt2), .sat_count(sat_count2), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic real p2(int n);
    real r;
    r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  // Magnitude of an FP8 code treated as finite (the code just above max is the overflow point).
  function automatic real fp8_val(int code, logic fmt);
    int mb, bias, ef, mf;
    mb   = fmt ? 2 : 3;
    bias = fmt ? 15 : 7;
    ef   = code >> mb;
    mf   = code & ((1 << mb) - 1);
    if (ef == 0) return real'(mf) * p2(1 - bias - mb);
    return real'((1 << mb) + mf) * p2(ef - bias - mb);
  endfunction

  // Nearest-code search with ties to the even code; returns {sat, byte}.
  function automatic logic [8:0] ref_conv(logic [31:0] x, logic fmt);
    logic s;
    int ex, maxc, best;
    real v, d, bd;
    s    = x[31];
    ex   = int'(x[30:23]);
    maxc = fmt ? 'h7b : 'h7e;
    if (ex == 255) begin
      if (x[22:0] != 0) return {1'b0, s, (fmt ? 7'h7e : 7'h7f)};
      return {1'b1, s, 7'(maxc)};
    end
    if (ex == 0) return {1'b0, s, 7'h00};
    v    = (1.0 + real'(x[22:0]) / p2(23)) * p2(ex - 127);
    best = 0;
    bd   = v;
    for (int c = 1; c <= maxc + 1; c++) begin
      d = fp8_val(c, fmt) - v;
      if (d < 0.0) d = -d;
      if (d < bd || (d == bd && (c % 2) == 0)) begin
        bd   = d;
        best = c;
      end
    end
    if (best > maxc) return {1'b1, s, 7'(maxc)};
    return {1'b0, s, 7'(best)};
  endfunction

  function automatic beat_t model_beat(logic [32*LANES-1:0] d, logic f);
    beat_t b;
    logic [8:0] r;
    b.fmt  = f;
    b.sat  = '0;
    b.data = '0;
    for (int i = 0; i < LANES; i++) begin
      r = ref_conv(d[32*i +: 32], f);
      b.sat[i] = r[8];
      b.data[8*i +: 8] = r[7:0];
    end
    return b;
  endfunction

  function automatic logic [31:0] rnd_fp32();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r[30:23] = 8'hff;
      1: r[30:23] = 8'h00;
      default: r[30:23] = 8'(100 + $urandom_range(0, 45));
    endcase
    return r;
  endfunction

  // Monitor: handshake rules, stall stability and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      check("in_ready", in_ready, !(sb.size() == 2 && !out_ready));
      if (prev_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_hold", {out_fmt, out_sat, out_data}, prev_out);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h, required none (t=%0t)", out_data, $time);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_sat", out_sat, e.sat);
          check("out_fmt", out_fmt, e.fmt);
        end
      end
      if (in_valid && in_ready) sb.push_back(use_table ? tab_exp : model_beat(in_data, in_fmt));
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_fmt, out_sat, out_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [32*LANES-1:0] d, logic f);
    logic acc;
    in_data  = d;
    in_fmt   = f;
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    if (!acc) check("send_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 200 && sb.size() != 0; n++) tick();
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{32'h3F800000, 1'b0, 8'h38, 1'b0};
    vt[1]  = '{32'hC0000000, 1'b0, 8'hC0, 1'b0};
    vt[2]  = '{32'h3F000000, 1'b0, 8'h30, 1'b0};
    vt[3]  = '{32'h3F800000, 1'b1, 8'h3C, 1'b0};
    vt[4]  = '{32'h3F880000, 1'b0, 8'h38, 1'b0};
    vt[5]  = '{32'h3F980000, 1'b0, 8'h3A, 1'b0};
    vt[6]  = '{32'h3B000000, 1'b0, 8'h01, 1'b0};
    vt[7]  = '{32'h00000001, 1'b0, 8'h00, 1'b0};
    vt[8]  = '{32'h43E00000, 1'b0, 8'h7E, 1'b0};
    vt[9]  = '{32'h447A0000, 1'b0, 8'h7E, 1'b1};
    vt[10] = '{32'hFF800000, 1'b0, 8'hFE, 1'b1};
    vt[11] = '{32'h7FC00000, 1'b0, 8'h7F, 1'b0};
    vt[12] = '{32'h7FC00000, 1'b1, 8'h7E, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_fmt = 1'b0; in_data = '0;
    out_ready = 1'b1; clr_cnt = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_sat", out_sat, '0);
    check("rst_out_fmt", out_fmt, 1'b0);
    check("rst_sat_count", sat_count, 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    // Constant vectors in lane 0, negative zero in lane 1.
    use_table = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tab_exp = '{fmt: vt[i].fmt, sat: {3'b000, vt[i].sat}, data: {16'h0, 8'h80, vt[i].d}};
      send({64'h0, 32'h80000000, vt[i].x}, vt[i].fmt);
      if (i == 0) begin
        check("latency_edge1", out_valid, 1'b0);
        tick();
        check("latency_edge2", out_valid, 1'b1);
      end
      drain();
    end
    check("table_sat_count", sat_count, 2);
    check("table_sat_count_small", sat_count2, 2);

    // Backpressure: 8 back-to-back beats, alternating format, random out_ready.
    use_table = 1'b0;
    fork
      begin
        for (int b = 0; b < 8; b++)
          send({rnd_fp32(), rnd_fp32(), rnd_fp32(), rnd_fp32()}, b[0]);
      end
      begin
        for (int c = 0; c < 40; c++) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Counter: clear, 3 fully saturating beats, then hold at max on the narrow copy.
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_idle", sat_count, 0);
    for (int b = 0; b < 3; b++) send({4{32'h447A0000}}, 1'b0);
    drain();
    check("cnt_12", sat_count, 12);
    check("cnt_12_small", sat_count2, 12);
    send({4{32'hC7800000}}, 1'b1);
    drain();
    check("cnt_16", sat_count, 16);
    check("cnt_hold_small", sat_count2, 15);
    send({4{32'h7F800000}}, 1'b0);
    drain();
    check("cnt_20", sat_count, 20);
    check("cnt_hold_small2", sat_count2, 15);

    // Clear coinciding with a saturating output handshake.
    send({4{32'h447A0000}}, 1'b0);
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    check("clr_beat_seen", out_valid, 1'b1);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_wins", sat_count, 0);
    check("clr_wins_small", sat_count2, 0);
    tick();
    check("clr_after", sat_count, 0);

    // Mid-stream reset with two beats stuck in the pipe.
    send({4{32'h447A0000}}, 1'b0);
    drain();
    check("pre_rst_count", sat_count, 4);
    out_ready = 1'b0;
    send({4{32'h3F800000}}, 1'b0);
    send({4{32'h447A0000}}, 1'b1);
    check("two_in_flight", sb.size(), 2);
    rst_n = 1'b0;
    tick();
    sb.delete();
    rst_n = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_sat_count", sat_count, 0);
    check("midrst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (10) tick();
    check("no_stale_valid", out_valid, 1'b0);
    check("no_stale_count", sat_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
